// File: rtl/pivot_row_swapper.sv
// Gaussian-elimination pivot step: holds the working matrix, issues column k to the
// pivot scanner, then swaps row k with the winner. Optional macro: PIVOT_PERM_TRACK_EN.
module pivot_row_swapper #(
   parameter int MAT_SIZE = 5,
   parameter int DATWIDTH = 64,
   parameter int TIMEOUT  = 63
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        ld_valid,
   input  logic [$clog2(MAT_SIZE):0]                   ld_row,
   input  logic [MAT_SIZE-1:0][DATWIDTH-1:0]           ld_data,
   input  logic                                        pivot_req,
   input  logic [$clog2(MAT_SIZE):0]                   pivot_k,
   output logic                                        busy,
   output logic                                        pivot_done,
   output logic                                        singular,
   output logic                                        timeout_err,
   output logic                                        scan_start,
   output logic [$clog2(MAT_SIZE):0]                   scan_opcnt,
   output logic [MAT_SIZE-1:0][DATWIDTH-1:0]           scan_col,
   input  logic                                        scan_done,
   input  logic                                        scan_err,
   input  logic [$clog2(MAT_SIZE):0]                   scan_winner,
   input  logic [$clog2(MAT_SIZE):0]                   rd_row,
   output logic [MAT_SIZE-1:0][DATWIDTH-1:0]           rd_data,
   output logic [MAT_SIZE-1:0][$clog2(MAT_SIZE):0]     perm
);
   localparam int IW = $clog2(MAT_SIZE) + 1;
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] MS     = IW'(MAT_SIZE);
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

   typedef logic [MAT_SIZE-1:0][DATWIDTH-1:0] row_t;
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SWAP, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           k_q, k_d, w_q, w_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    sing_q, sing_d, to_q, to_d;
   row_t [MAT_SIZE-1:0]     mat_q, mat_d;
   row_t                    rd_q, rd_d;
   row_t                    row_k, row_w;
   logic                    do_swap;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         w_q     <= '0;
         cnt_q   <= '0;
         sing_q  <= 1'b0;
         to_q    <= 1'b0;
         mat_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         w_q     <= w_d;
         cnt_q   <= cnt_d;
         sing_q  <= sing_d;
         to_q    <= to_d;
         mat_q   <= mat_d;
         rd_q    <= rd_d;
      end
   end

   // Row k and the winning row, picked out for the swap.
   always_comb begin
      row_k = '0;
      row_w = '0;
      for (int r = 0; r < MAT_SIZE; r++) begin
         if (k_q == IW'(r)) row_k = mat_q[r];
         if (w_q == IW'(r)) row_w = mat_q[r];
      end
   end

   assign do_swap = (state_q == S_SWAP) && (w_q != k_q) && (w_q < MS) && (k_q < MS);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      w_d     = w_q;
      cnt_d   = cnt_q;
      sing_d  = sing_q;
      to_d    = to_q;
      mat_d   = mat_q;
      case (state_q)
         S_IDLE: begin
            if (ld_valid) begin
               for (int r = 0; r < MAT_SIZE; r++)
                  if (ld_row == IW'(r)) mat_d[r] = ld_data;
            end
            if (pivot_req) begin
               k_d = pivot_k;
               if (pivot_k < MS) begin
                  sing_d  = 1'b0;
                  to_d    = 1'b0;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A done pulse on the final cycle still counts as an answer.
            if (scan_done) begin
               if (scan_err) begin
                  sing_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  w_d     = scan_winner;
                  state_d = S_SWAP;
               end
            end else if (cnt_q + 1'b1 == TO_LIM) begin
               to_d    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_SWAP: begin
            if (do_swap) begin
               for (int r = 0; r < MAT_SIZE; r++) begin
                  if (k_q == IW'(r)) mat_d[r] = row_w;
                  if (w_q == IW'(r)) mat_d[r] = row_k;
               end
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_d = '0;
      for (int r = 0; r < MAT_SIZE; r++)
         if (rd_row == IW'(r)) rd_d = mat_q[r];
   end

   // Column k by absolute row; the matrix is frozen while busy so this stays stable.
   always_comb begin
      scan_col = '0;
      for (int r = 0; r < MAT_SIZE; r++)
         for (int c = 0; c < MAT_SIZE; c++)
            if (k_q == IW'(c)) scan_col[r] = mat_q[r][c];
   end

   assign busy        = (state_q != S_IDLE);
   assign pivot_done  = (state_q == S_DONE);
   assign scan_start  = (state_q == S_ISSUE);
   assign scan_opcnt  = k_q;
   assign singular    = sing_q;
   assign timeout_err = to_q;
   assign rd_data     = rd_q;

`ifdef PIVOT_PERM_TRACK_EN
   logic [MAT_SIZE-1:0][IW-1:0] perm_q, perm_d;
   logic [IW-1:0]               pk, pw;

   always_comb begin
      pk = '0;
      pw = '0;
      for (int r = 0; r < MAT_SIZE; r++) begin
         if (k_q == IW'(r)) pk = perm_q[r];
         if (w_q == IW'(r)) pw = perm_q[r];
      end
      perm_d = perm_q;
      if (do_swap) begin
         for (int r = 0; r < MAT_SIZE; r++) begin
            if (k_q == IW'(r)) perm_d[r] = pw;
            if (w_q == IW'(r)) perm_d[r] = pk;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAT_SIZE; i++) perm_q[i] <= IW'(i);
      end else begin
         perm_q <= perm_d;
      end
   end

   assign perm = perm_q;
`else
   for (genvar i = 0; i < MAT_SIZE; i++) begin : g_perm_id
      assign perm[i] = IW'(i);
   end
`endif

endmodule
